// File: rtl/sprite_palette_bank.sv
// Sprite palette lookup: NUM_PAL palettes of 2**IDX_W {R,G,B} entries, 2-cycle read pipeline.
// Define PALETTE_FLASH_EN to build the frame-based hit-flash overlay; undefined gives plain lookup.
module sprite_palette_bank #(
    parameter int IDX_W        = 4,
    parameter int NUM_PAL      = 4,
    parameter int COLOR_W      = 4,
    parameter int TRANSP_IDX   = 0,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         pix_valid,
    input  logic [$clog2(NUM_PAL)-1:0]   pal_sel,
    input  logic [IDX_W-1:0]             index,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_PAL)-1:0]   wr_pal,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [3*COLOR_W-1:0]         wr_data,
    input  logic                         frame_start,
    input  logic                         flash_trig,
    output logic [COLOR_W-1:0]           red,
    output logic [COLOR_W-1:0]           green,
    output logic [COLOR_W-1:0]           blue,
    output logic                         out_valid,
    output logic                         transparent,
    output logic                         flashing
);
    localparam int PAL_W   = $clog2(NUM_PAL);
    localparam int ADDR_W  = PAL_W + IDX_W;
    localparam int DEPTH   = NUM_PAL << IDX_W;
    localparam int ENTRY_W = 3 * COLOR_W;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [ENTRY_W-1:0] r_rd_data;
    logic               r_transp1;
    logic [1:0]         r_vld_pipe;
    logic               w_flash_on;
    logic [ENTRY_W-1:0] w_out;

    // Storage has no reset and keeps writing during Reset; the nonblocking
    // write makes a same-cycle read see the old entry.
    always_ff @(posedge Clk) begin
        if (wr_en)
            r_mem[{wr_pal, wr_idx}] <= wr_data;
        r_rd_data <= r_mem[ADDR_W'({pal_sel, index})];
        r_transp1 <= (index == IDX_W'(TRANSP_IDX));
    end

`ifdef PALETTE_FLASH_EN
    localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, FLASH_ON, FLASH_OFF} flash_state_t;

    flash_state_t     r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A trigger outranks a coincident frame_start and restarts an active flash.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flash_trig) begin
            w_state_nxt = FLASH_ON;
            w_cnt_nxt   = CNT_W'(FLASH_FRAMES);
        end else if (frame_start && r_state != IDLE) begin
            if (r_cnt <= CNT_W'(1)) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = (r_state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
                w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        flashing   = (r_state != IDLE);
        w_flash_on = (r_state == FLASH_ON);
    end
`else
    localparam int w_unused_frames = FLASH_FRAMES;
    logic w_unused_flash;

    always_comb begin
        w_unused_flash = flash_trig ^ frame_start;
        flashing       = 1'b0;
        w_flash_on     = 1'b0;
    end
`endif

    // Flash state is sampled here, on the edge that raises out_valid.
    always_comb begin
        w_out = r_rd_data;
        if (w_flash_on && !r_transp1)
            w_out = '1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_vld_pipe  <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            transparent <= 1'b0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], pix_valid};
            if (r_vld_pipe[0]) begin
                red         <= w_out[3*COLOR_W-1:2*COLOR_W];
                green       <= w_out[2*COLOR_W-1:COLOR_W];
                blue        <= w_out[COLOR_W-1:0];
                transparent <= r_transp1;
            end
        end
    end

    assign out_valid = r_vld_pipe[1];
endmodule
